// File: rtl/audio_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// audio_pkg : shared audio sample widths and the stereo frame type
// rev 1.0
// ----------------------------------------------------------------------------
package audio_pkg;

  localparam int AUDIO_SAMPLE_W = 24;

  typedef logic signed [AUDIO_SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_frame_t;

endpackage
`default_nettype wire

// File: rtl/sample_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sample_ram : frame storage, one synchronous write port, asynchronous read
// rev 1.0
// ----------------------------------------------------------------------------
module sample_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // Unreset array so synthesis can map it onto distributed RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/stereo_sample_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stereo_sample_fifo : host-to-I2S stereo frame FIFO with underrun tracking
// rev 1.0
// ----------------------------------------------------------------------------
module stereo_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int SAMPLE_W   = AUDIO_SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [SAMPLE_W-1:0]   wr_l,
  input  logic [SAMPLE_W-1:0]   wr_r,
  output logic                  wr_ready,
  input  logic                  load,
  output logic [SAMPLE_W-1:0]   l_data,
  output logic [SAMPLE_W-1:0]   r_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  data_req,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] HALF_LEVEL = (DEPTH_LOG2+1)'(1) << (DEPTH_LOG2-1);

  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [2*SAMPLE_W-1:0]   head_frame;
  logic                    wr_fire;
  logic                    pop;
  logic                    empty_load;

  assign wr_ready   = !reset && (level != FULL_LEVEL);
  assign data_req   = (level <= HALF_LEVEL);
  assign wr_fire    = wr_valid && wr_ready;
  assign pop        = load && (level != '0);
  assign empty_load = load && (level == '0);

  sample_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (2*SAMPLE_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata ({wr_l, wr_r}),
    .raddr (rd_ptr),
    .rdata (head_frame)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      l_data   <= '0;
      r_data   <= '0;
      underrun <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      // A write into an empty FIFO never falls through to the outputs.
      if (pop) begin
        rd_ptr           <= rd_ptr + 1'b1;
        {l_data, r_data} <= head_frame;
      end else if (empty_load) begin
        l_data <= '0;
        r_data <= '0;
      end

      case ({wr_fire, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (empty_load) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stereo_sample_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_stereo_sample_fifo : table-driven and randomized checks against a queue model
// rev 1.0
// ----------------------------------------------------------------------------
module tb_stereo_sample_fifo;
  import audio_pkg::*;

  localparam int DL2 = 4;
  localparam int SW  = 24;
  localparam int CAP = 1 << DL2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic [SW-1:0] wr_l = '0;
  logic [SW-1:0] wr_r = '0;
  logic          wr_ready;
  logic          load = 1'b0;
  logic [SW-1:0] l_data;
  logic [SW-1:0] r_data;
  logic [DL2:0]  level;
  logic          data_req;
  logic          underrun;
  logic          underrun_clr = 1'b0;

  stereo_sample_fifo #(.DEPTH_LOG2(DL2), .SAMPLE_W(SW)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_l         (wr_l),
    .wr_r         (wr_r),
    .wr_ready     (wr_ready),
    .load         (load),
    .l_data       (l_data),
    .r_data       (r_data),
    .level        (level),
    .data_req     (data_req),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of frames plus the presented outputs.
  stereo_frame_t q[$];
  logic [SW-1:0] m_l = '0;
  logic [SW-1:0] m_r = '0;
  logic          m_under = 1'b0;
  logic          m_rst = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic wv, input logic [SW-1:0] l, input logic [SW-1:0] r,
                       input logic ld, input logic clr, input logic rs);
    logic fire;
    logic empty_ld;
    stereo_frame_t f;
    wr_valid = wv; wr_l = l; wr_r = r; load = ld; underrun_clr = clr; reset = rs;
    fire = wv && !rs && (q.size() < CAP);
    if (rs) begin
      q.delete();
      m_l = '0; m_r = '0; m_under = 1'b0;
    end else begin
      empty_ld = 1'b0;
      if (ld) begin
        if (q.size() > 0) begin
          f = q.pop_front();
          m_l = f.left; m_r = f.right;
        end else begin
          m_l = '0; m_r = '0; empty_ld = 1'b1;
        end
      end
      if (fire) begin
        f.left = l; f.right = r;
        q.push_back(f);
      end
      if (empty_ld) m_under = 1'b1;
      else if (clr) m_under = 1'b0;
    end
    m_rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".l_data"}, 64'(l_data), 64'(m_l));
    check({tag, ".r_data"}, 64'(r_data), 64'(m_r));
    check({tag, ".level"}, 64'(level), 64'(q.size()));
    check({tag, ".wr_ready"}, 64'(wr_ready), 64'(!m_rst && q.size() < CAP));
    check({tag, ".data_req"}, 64'(data_req), 64'(q.size() <= CAP/2));
    check({tag, ".underrun"}, 64'(underrun), 64'(m_under));
  endtask

  typedef struct {
    logic          wv;
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic          ld;
    logic          clr;
    logic          rs;
    logic [SW-1:0] el;
    logic [SW-1:0] er;
    int            elev;
    logic          eund;
    logic          erdy;
  } vec_t;

  vec_t vt[11];

  initial begin
    // Directed vectors: basic write/load, underrun set/clear, write+load on empty.
    vt[0]  = '{0, 24'h0,      24'h0,      0, 0, 1, 24'h0,      24'h0,      0, 0, 0};
    vt[1]  = '{1, 24'h123456, 24'hABCDEF, 0, 0, 0, 24'h0,      24'h0,      1, 0, 1};
    vt[2]  = '{0, 24'h0,      24'h0,      1, 0, 0, 24'h123456, 24'hABCDEF, 0, 0, 1};
    vt[3]  = '{0, 24'h0,      24'h0,      1, 0, 0, 24'h0,      24'h0,      0, 1, 1};
    vt[4]  = '{0, 24'h0,      24'h0,      0, 1, 0, 24'h0,      24'h0,      0, 0, 1};
    vt[5]  = '{0, 24'h0,      24'h0,      1, 0, 0, 24'h0,      24'h0,      0, 1, 1};
    vt[6]  = '{0, 24'h0,      24'h0,      1, 1, 0, 24'h0,      24'h0,      0, 1, 1};
    vt[7]  = '{0, 24'h0,      24'h0,      0, 1, 0, 24'h0,      24'h0,      0, 0, 1};
    vt[8]  = '{1, 24'h111111, 24'h222222, 1, 0, 0, 24'h0,      24'h0,      1, 1, 1};
    vt[9]  = '{0, 24'h0,      24'h0,      1, 0, 0, 24'h111111, 24'h222222, 0, 1, 1};
    vt[10] = '{0, 24'h0,      24'h0,      0, 1, 0, 24'h111111, 24'h222222, 0, 0, 1};

    cycle(0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 11; i++) begin
      cycle(vt[i].wv, vt[i].l, vt[i].r, vt[i].ld, vt[i].clr, vt[i].rs);
      check($sformatf("vec%0d.l_data", i), 64'(l_data), 64'(vt[i].el));
      check($sformatf("vec%0d.r_data", i), 64'(r_data), 64'(vt[i].er));
      check($sformatf("vec%0d.level", i), 64'(level), 64'(vt[i].elev));
      check($sformatf("vec%0d.underrun", i), 64'(underrun), 64'(vt[i].eund));
      check($sformatf("vec%0d.wr_ready", i), 64'(wr_ready), 64'(vt[i].erdy));
    end

    // Fill to full, refused 17th write, drain in order.
    cycle(0, '0, '0, 0, 1, 0);
    for (int i = 0; i < CAP; i++) cycle(1, SW'(24'h100000 + i), SW'(24'h200000 + i), 0, 0, 0);
    check("full.level", 64'(level), 64'(CAP));
    check("full.wr_ready", 64'(wr_ready), 64'(0));
    check("full.data_req", 64'(data_req), 64'(0));
    cycle(1, 24'hDEAD00, 24'hBEEF00, 0, 0, 0);
    check("full.refused", 64'(level), 64'(CAP));
    cycle(1, 24'hDEAD01, 24'hBEEF01, 1, 0, 0);
    check("full.pop_l", 64'(l_data), 64'(24'h100000));
    check("full.ready_after_pop", 64'(wr_ready), 64'(1));
    check_model("full");
    for (int i = 0; i < CAP - 1; i++) begin
      cycle(0, '0, '0, 1, 0, 0);
      check_model("drain");
    end

    // Fill to 10, reset one cycle, only the new frame comes back.
    for (int i = 0; i < 10; i++) cycle(1, SW'(24'h300000 + i), SW'(24'h400000 + i), 0, 0, 0);
    check("pre_rst.level", 64'(level), 64'(10));
    cycle(0, '0, '0, 0, 0, 1);
    check_model("rst");
    check("rst.level", 64'(level), 64'(0));
    cycle(1, 24'h5A5A5A, 24'hA5A5A5, 0, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);
    check("post_rst.l", 64'(l_data), 64'(24'h5A5A5A));
    check("post_rst.r", 64'(r_data), 64'(24'hA5A5A5));
    check_model("post_rst");

    // Stream 40 frames, load every 256 cycles, host refills on data_req.
    begin
      int wrote = 0;
      int popped = 0;
      int cyc = 0;
      while (popped < 40 && cyc < 20000) begin
        logic ld;
        logic wv;
        ld = (cyc % 256) == 255;
        wv = (wrote < 40) && (q.size() <= CAP/2);
        if (ld && q.size() > 0) popped++;
        cycle(wv, SW'(24'h600000 + wrote), SW'(24'h700000 + wrote), ld, 0, 0);
        if (wv) wrote++;
        if (ld) check_model("stream");
        cyc++;
      end
      check("stream.popped", 64'(popped), 64'(40));
      check("stream.no_underrun", 64'(underrun), 64'(0));
    end

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 3) != 0, SW'($urandom), SW'($urandom),
            ($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 300) == 0);
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stereo_sample_fifo.md
STEREO_SAMPLE_FIFO -- requirements
Module: stereo_sample_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4: FIFO depth = 2^DEPTH_LOG2 stereo frames.
REQ-002 Parameter SAMPLE_W, default 24: width of each channel sample, two's complement.
REQ-003 clk  input  1  system clock; also the I2S MCLK domain.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 wr_valid  input  1  host offers a stereo frame this cycle.
REQ-006 wr_l  input  SAMPLE_W  left sample offered.
REQ-007 wr_r  input  SAMPLE_W  right sample offered.
REQ-008 wr_ready  output  1  FIFO can accept a frame this cycle.
REQ-009 load  input  1  one-cycle sample-rate strobe from the I2S output stage.
REQ-010 l_data  output  SAMPLE_W  registered left sample presented to the I2S stage.
REQ-011 r_data  output  SAMPLE_W  registered right sample presented to the I2S stage.
REQ-012 level  output  DEPTH_LOG2+1  frames currently stored, 0..2^DEPTH_LOG2.
REQ-013 data_req  output  1  refill request to host.
REQ-014 underrun  output  1  sticky underrun flag.
REQ-015 underrun_clr  input  1  one-cycle clear of underrun.

Function
REQ-016 Write accepted on a rising clk when wr_valid & wr_ready; frame {wr_l,wr_r} stored at write pointer, pointer increments modulo depth.
REQ-017 wr_ready SHALL be high exactly when level < 2^DEPTH_LOG2 and reset is low; combinational from registered state only, never from wr_valid or load.
REQ-018 On load with level > 0: head frame SHALL appear on l_data/r_data on the cycle after load; read pointer increments modulo depth.
REQ-019 On load with level = 0: l_data/r_data SHALL become zero on the cycle after load; underrun SHALL be set on that same cycle.
REQ-020 l_data/r_data SHALL hold their value between loads; the I2S stage captures them on its load cycle, so a popped frame is serialised one frame period later (fixed one-frame pipeline).
REQ-021 Simultaneous accepted write and load: level unchanged if it was > 0; if level was 0, the written frame is stored (no fall-through), outputs go to zero, underrun sets, level becomes 1.
REQ-022 Load while full: pop proceeds; wr_ready remains low that cycle, goes high next cycle.
REQ-023 level SHALL increment on write-only, decrement on non-empty pop-only, otherwise hold; never exceeds 2^DEPTH_LOG2 nor goes below 0.
REQ-024 data_req SHALL be high when level <= 2^(DEPTH_LOG2-1).
REQ-025 underrun_clr clears underrun on the next cycle; a new underrun in the same cycle as underrun_clr SHALL leave underrun set.
REQ-026 Pointers are DEPTH_LOG2 bits and wrap from 2^DEPTH_LOG2-1 to 0 with no lost or duplicated frame.

Reset
REQ-027 During reset: read/write pointers, level, l_data, r_data and underrun SHALL be zero; wr_ready low; data_req high.
REQ-028 Reset mid-operation SHALL discard all stored frames; the first write after reset lands in entry 0.
REQ-029 Storage array contents need no reset.

Structure
REQ-030 Shared package audio_pkg holds SAMPLE_W default (24) and the stereo-frame type {left,right} reused by i2s_out and this block.
REQ-031 Storage SHALL be one sub-module, sample_ram: 2^DEPTH_LOG2 x 2*SAMPLE_W, one synchronous write port, one asynchronous or registered read port, inferable as distributed RAM.
REQ-032 Pointer, level and flag logic SHALL live in stereo_sample_fifo; no additional state machine beyond the counters.

Verification
REQ-033 Write L=0x123456,R=0xABCDEF, then load -> next cycle l_data=0x123456, r_data=0xABCDEF, level 1->0.
REQ-034 Write 16 frames (DEPTH_LOG2=4) -> level=16, wr_ready=0, data_req=0; 17th wr_valid not accepted; 16 loads return frames in order, wr_ready=1 after first pop.
REQ-035 Load with level=0 -> outputs 0, underrun=1; underrun_clr pulse -> underrun=0; clr coincident with second empty load -> underrun stays 1.
REQ-036 Empty FIFO, write and load same cycle -> outputs 0, underrun=1, level=1; next load outputs written frame.
REQ-037 Stream 40 frames through with loads every 256 cycles and host writes on data_req -> frame order preserved across pointer wrap, no underrun.
REQ-038 Fill to 10, assert reset one cycle -> level=0, outputs 0, underrun=0; next write/load returns new frame only.
